// File: rtl/apb_cmd_master_pkg.sv
// apb_cmd_master shared types.
// States, latched command and response bundles.
package apb_cmd_master_pkg;

  localparam int ADDR_MAX = 32;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic [DATA_W-1:0]   wdata;
    logic                write;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              timeout;
  } rsp_t;

  // Watchdog width; never below one bit.
  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB3 bus.
// master = initiator view, slave = environment view.
interface apb_cmd_master_if #(
  parameter int AW = 12
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    input  req_valid, req_write,
    input  req_addr, req_wdata,
    input  rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready,
    output rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    output PADDR, PWDATA, PWRITE,
    output PSEL, PENABLE
  );

  modport slave (
    output req_valid, req_write,
    output req_addr, req_wdata,
    output rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    input  PADDR, PWDATA, PWRITE,
    input  PSEL, PENABLE
  );

endinterface

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 initiator with
// valid/ready command port and watchdog.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  apb_cmd_master_if.master  bus
);

  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIM =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  state_t        r_state;
  state_t        w_next;
  cmd_t          r_cmd;
  rsp_t          r_rsp;
  rsp_t          w_rsp;
  logic [CW-1:0] r_cnt;
  logic          w_limit;

  assign w_limit = (TIMEOUT_CYCLES != 0) &&
                   (r_cnt == LIM);

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state, bus strobes and completion value.
  always_comb begin
    w_next          = r_state;
    w_rsp           = r_rsp;
    bus.req_ready   = 1'b0;
    bus.rsp_valid   = 1'b0;
    bus.PSEL        = 1'b0;
    bus.PENABLE     = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_next = SETUP;
      end
      SETUP: begin
        bus.PSEL = 1'b1;
        w_next   = ACCESS;
      end
      ACCESS: begin
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        if (bus.PREADY) begin
          w_next        = RESP;
          w_rsp.rdata   = (r_cmd.write || bus.PSLVERR)
                          ? 32'd0 : bus.PRDATA;
          w_rsp.err     = bus.PSLVERR;
          w_rsp.timeout = 1'b0;
        end else if (w_limit) begin
          w_next        = RESP;
          w_rsp.rdata   = 32'd0;
          w_rsp.err     = 1'b1;
          w_rsp.timeout = 1'b1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Command latch, response capture, watchdog.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cmd <= '0;
      r_rsp <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_cmd.addr  <= ADDR_MAX'(bus.req_addr);
        r_cmd.write <= bus.req_write;
        r_cmd.wdata <= bus.req_write
                       ? bus.req_wdata : 32'd0;
      end
      if (r_state == ACCESS && w_next == RESP)
        r_rsp <= w_rsp;
      if (r_state == SETUP)
        r_cnt <= '0;
      else if (r_state == ACCESS && r_cnt != CMAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.PADDR       = APB_ADDR_WIDTH'(r_cmd.addr);
  assign bus.PWDATA      = r_cmd.wdata;
  assign bus.PWRITE      = r_cmd.write;
  assign bus.rsp_rdata   = r_rsp.rdata;
  assign bus.rsp_err     = r_rsp.err;
  assign bus.rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master.
// Hand-computed expectations, TIMEOUT_CYCLES=4.
module tb_apb_cmd_master;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  apb_cmd_master_if #(.AW(12)) bus ();

  apb_cmd_master #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic chk_bus(input string tag,
                         input logic psel,
                         input logic pen,
                         input logic rdy,
                         input logic rv);
    chk({tag, ".psel"}, 32'(bus.PSEL), 32'(psel));
    chk({tag, ".pen"}, 32'(bus.PENABLE), 32'(pen));
    chk({tag, ".rqrdy"}, 32'(bus.req_ready), 32'(rdy));
    chk({tag, ".rspv"}, 32'(bus.rsp_valid), 32'(rv));
  endtask

  task automatic chk_rsp(input string tag,
                         input logic [31:0] rd,
                         input logic err,
                         input logic to);
    chk({tag, ".rdata"}, bus.rsp_rdata, rd);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(err));
    chk({tag, ".to"}, 32'(bus.rsp_timeout), 32'(to));
  endtask

  initial begin
    n_chk           = 0;
    n_pass          = 0;
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.rsp_ready   = 1'b0;
    bus.PRDATA      = '0;
    bus.PREADY      = 1'b0;
    bus.PSLVERR     = 1'b0;
    #1;
    chk_bus("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    chk_rsp("rst", 32'd0, 1'b0, 1'b0);
    chk("rst.paddr", 32'(bus.PADDR), 32'd0);
    chk("rst.pwdata", bus.PWDATA, 32'd0);
    chk("rst.pwrite", 32'(bus.PWRITE), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Zero-wait write.
    bus.PREADY    = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 12'h004;
    bus.req_wdata = 32'hDEADBEEF;
    tick();
    bus.req_valid = 1'b0;
    chk_bus("wr.c1", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wr.paddr", 32'(bus.PADDR), 32'h004);
    chk("wr.pwdata", bus.PWDATA, 32'hDEADBEEF);
    chk("wr.pwrite", 32'(bus.PWRITE), 32'd1);
    tick();
    chk_bus("wr.c2", 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_bus("wr.c3", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_rsp("wr.c3", 32'd0, 1'b0, 1'b0);
    tick();
    chk_bus("wr.c4", 1'b0, 1'b0, 1'b1, 1'b0);

    // Read with 3 wait states; PREADY on the
    // 4th ACCESS cycle also beats the limit.
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'hDEAD0000;
    bus.PSLVERR   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 12'h008;
    bus.req_wdata = 32'h12345678;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 12'hFFF;
    chk_bus("rdw.setup", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rdw.pwdata", bus.PWDATA, 32'd0);
    chk("rdw.pwrite", 32'(bus.PWRITE), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bus($sformatf("rdw.acc%0d", i),
              1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("rdw.paddr%0d", i),
          32'(bus.PADDR), 32'h008);
      if (i == 3) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h000000A5;
      end
    end
    tick();
    chk_bus("rdw.resp", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_rsp("rdw.resp", 32'hA5, 1'b0, 1'b0);
    tick();

    // Read with slave error.
    bus.PRDATA    = 32'h00005555;
    bus.PSLVERR   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h00C;
    tick();
    bus.req_valid = 1'b0;
    repeat (2) tick();
    chk_bus("err.resp", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_rsp("err.resp", 32'd0, 1'b1, 1'b0);
    tick();
    bus.PSLVERR = 1'b0;

    // Timeout, PREADY stuck low.
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'h0000BEEF;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h010;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bus($sformatf("to.acc%0d", i),
              1'b1, 1'b1, 1'b0, 1'b0);
    end
    tick();
    chk_bus("to.resp", 1'b0, 1'b0, 1'b0, 1'b1);
    chk_rsp("to.resp", 32'd0, 1'b1, 1'b1);
    tick();
    chk_bus("to.idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back, response back-pressured.
    bus.PREADY    = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 12'h010;
    bus.req_wdata = 32'h11111111;
    tick();
    bus.req_write = 1'b0;
    bus.req_addr  = 12'h020;
    bus.PRDATA    = 32'h00000077;
    repeat (2) tick();
    chk_rsp("b2b.r0", 32'd0, 1'b0, 1'b0);
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      chk_bus($sformatf("b2b.hold%0d", i),
              1'b0, 1'b0, 1'b0, 1'b1);
      chk_rsp($sformatf("b2b.hold%0d", i),
              32'd0, 1'b0, 1'b0);
      chk($sformatf("b2b.pa%0d", i),
          32'(bus.PADDR), 32'h010);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk_bus("b2b.idle", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.PREADY    = 1'b0;
    chk_bus("b2b.setup2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b.paddr2", 32'(bus.PADDR), 32'h020);
    chk("b2b.pwr2", 32'(bus.PWRITE), 32'd0);
    tick();
    chk_bus("b2b.acc2", 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset during ACCESS.
    #2;
    rst_n = 1'b0;
    #1;
    chk_bus("rst2", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst2.paddr", 32'(bus.PADDR), 32'd0);
    chk_rsp("rst2", 32'd0, 1'b0, 1'b0);
    tick();
    rst_n         = 1'b1;
    bus.PREADY    = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bus($sformatf("rst2.post%0d", i),
              1'b0, 1'b0, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
